// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding constants for the instruction encoder and the core decoder.
// Holds the abstract operation enum, opcode/funct fields and an immediate range helper.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_OR      = 3'd2,
        OP_AND     = 3'd3,
        OP_BEQ     = 3'd4,
        OP_LW      = 3'd5,
        OP_SW      = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam int REG_W  = 5;
    localparam int IMM_W  = 13;
    localparam int INST_W = 32;

    // A 13-bit immediate fits 12-bit signed only if the top two bits agree.
    function automatic logic fits_simm12(input logic [IMM_W-1:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/inst_fmt.sv
// Combinational field packer: abstract operation plus operands to a 32-bit RV32I word.
// Flags requests the decoder could not represent instead of producing a word.
module inst_fmt
    import inst_encoder_pkg::*;
(
    input  op_e               op,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [IMM_W-1:0]  imm,
    output logic [INST_W-1:0] inst,
    output logic              illegal
);

    always_comb begin
        inst    = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD: inst = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
            OP_SUB: inst = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
            OP_OR:  inst = {F7_BASE, rs2, rs1, F3_OR,      rd, OPC_OP};
            OP_AND: inst = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_OP};
            OP_LW: begin
                inst    = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
                illegal = !fits_simm12(imm);
            end
            OP_SW: begin
                inst    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
                illegal = !fits_simm12(imm);
            end
            OP_BEQ: begin
                // Branch offsets are halfword aligned, so imm[0] has no slot in the word.
                inst    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                illegal = imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streams encoded RV32I words with word addresses toward the instruction RAM write port.
// One-deep output register with valid/ready flow control and a sticky illegal-request flag.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic              out_valid_reg, out_valid_next;
    logic [INST_W-1:0] out_inst_reg, out_inst_next;
    logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
    logic              err_reg, err_next;

    logic              accept;
    logic              out_fire;
    logic [INST_W-1:0] fmt_inst;
    logic              fmt_illegal;

    inst_fmt u_fmt (
        .op      (op_e'(in_op)),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .inst    (fmt_inst),
        .illegal (fmt_illegal)
    );

    assign in_ready = !restart && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_reg && out_ready;

    always_comb begin
        out_valid_next = out_valid_reg;
        out_inst_next  = out_inst_reg;
        out_addr_next  = out_addr_reg;
        err_next       = err_reg;
        if (restart) begin
            out_valid_next = 1'b0;
            out_inst_next  = '0;
            out_addr_next  = BASE;
            err_next       = 1'b0;
        end else begin
            // Address wraps naturally at 2^ADDR_W, back to 0 rather than BASE.
            if (out_fire) begin
                out_addr_next  = out_addr_reg + 1'b1;
                out_valid_next = 1'b0;
            end
            if (accept) begin
                if (fmt_illegal) begin
                    err_next = 1'b1;
                end else begin
                    out_valid_next = 1'b1;
                    out_inst_next  = fmt_inst;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_inst_reg  <= '0;
            out_addr_reg  <= BASE;
            err_reg       <= 1'b0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_inst_reg  <= out_inst_next;
            out_addr_reg  <= out_addr_next;
            err_reg       <= err_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_inst  = out_inst_reg;
    assign out_addr  = out_addr_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed test-plan steps, then random traffic
// against an arithmetic encoding model with a one-entry expected-word queue.
module tb_inst_encoder;

    localparam int AW    = 10;
    localparam int BASE  = 0;
    localparam int AW2   = 2;
    localparam int BASE2 = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, restart, in_valid, in_ready, out_valid, out_ready, err;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;
    logic [31:0] out_inst;
    logic [AW-1:0] out_addr;

    logic        rst_n_w, restart_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w, err_w;
    logic [31:0] out_inst_w;
    logic [AW2-1:0] out_addr_w;

    inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err(err)
    );

    inst_encoder #(.ADDR_W(AW2), .BASE_ADDR(BASE2)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .restart(restart_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_inst(out_inst_w), .out_addr(out_addr_w),
        .err(err_w)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] pend_q[$];
    int          m_addr;
    bit          m_err;

    // Bit 32 is "legal"; bits 31:0 are the word, assembled arithmetically from field values.
    function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input logic [12:0] imm);
        int          iv;
        int unsigned u, w, regs;
        bit          legal;
        iv = int'(imm);
        if (iv > 4095) iv = iv - 8192;
        u = unsigned'(iv);
        legal = 1'b1;
        w = 0;
        regs = (unsigned'(rs2) << 20) + (unsigned'(rs1) << 15);
        case (op)
            0: w = regs + (unsigned'(rd) << 7) + 51;
            1: w = (32 << 25) + regs + (unsigned'(rd) << 7) + 51;
            2: w = regs + (6 << 12) + (unsigned'(rd) << 7) + 51;
            3: w = regs + (7 << 12) + (unsigned'(rd) << 7) + 51;
            4: begin
                legal = (iv % 2) == 0;
                w = (((u >> 12) & 1) << 31) + (((u >> 5) & 63) << 25) + regs
                  + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7) + 99;
            end
            5: begin
                legal = (iv >= -2048) && (iv <= 2047);
                w = ((u & 32'hFFF) << 20) + (unsigned'(rs1) << 15) + (2 << 12) + (unsigned'(rd) << 7) + 3;
            end
            6: begin
                legal = (iv >= -2048) && (iv <= 2047);
                w = (((u >> 5) & 127) << 25) + regs + (2 << 12) + ((u & 31) << 7) + 35;
            end
            default: legal = 1'b0;
        endcase
        return {legal, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input int op, input int rd, input int rs1, input int rs2, input int imm);
        in_valid = 1'b1;
        in_op    = 3'(op);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = 13'(imm);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic chk_ready(input string tag);
        #1;
        chk(tag, 32'(in_ready), 32'(!restart && (pend_q.size() == 0 || out_ready)));
    endtask

    // Advance the model with the inputs presented this cycle, then step the DUT one edge.
    task automatic tick();
        logic [32:0] enc;
        bit hs, acc;
        enc = ref_enc(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm);
        if (restart) begin
            pend_q.delete();
            m_addr = BASE;
            m_err  = 1'b0;
        end else begin
            hs  = (pend_q.size() > 0) && out_ready;
            acc = in_valid && ((pend_q.size() == 0) || out_ready);
            if (hs) begin
                void'(pend_q.pop_front());
                m_addr = (m_addr + 1) % (1 << AW);
            end
            if (acc) begin
                if (enc[32]) pend_q.push_back(enc[31:0]);
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(pend_q.size() > 0));
        if (pend_q.size() > 0) chk({tag, "_inst"}, out_inst, pend_q[0]);
        chk({tag, "_addr"}, 32'(out_addr), 32'(m_addr));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; out_ready = 1'b1;
        rst_n_w = 1'b0; restart_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;
        req(0, 0, 0, 0, 0);
        idle();
        m_addr = BASE; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_addr", 32'(out_addr), 32'(BASE));
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1; rst_n_w = 1'b1;

        // ADD
        req(0, 3, 1, 2, 0); chk_ready("add_rdy"); tick(); idle();
        chk("add_word", out_inst, 32'h002081B3);
        chk("add_addr", 32'(out_addr), 32'd0);
        check_state("add");
        tick(); check_state("add_drain");
        restart = 1'b1; chk_ready("rst1_rdy"); tick(); restart = 1'b0;
        check_state("restart1");

        // SUB then LW back to back
        req(1, 5, 6, 7, 0); tick();
        chk("sub_word", out_inst, 32'h407302B3);
        chk("sub_addr", 32'(out_addr), 32'd0);
        req(5, 4, 2, 0, 13'h1FFC); chk_ready("lw_rdy"); tick(); idle();
        chk("lw_word", out_inst, 32'hFFC12203);
        chk("lw_addr", 32'(out_addr), 32'd1);
        tick(); check_state("lw_drain");

        // SW with a three-cycle stall; a competing request must not get in
        out_ready = 1'b0;
        req(6, 0, 1, 5, 8); chk_ready("sw_rdy"); tick();
        req(3, 9, 9, 9, 0);
        for (int i = 0; i < 3; i++) begin
            chk_ready("stall_rdy");
            chk("stall_in_ready_low", 32'(in_ready), 32'd0);
            tick();
            chk("stall_word", out_inst, 32'h0050A423);
            chk("stall_addr", 32'(out_addr), 32'd2);
            check_state("stall");
        end
        idle(); out_ready = 1'b1; chk_ready("unstall_rdy"); tick();
        chk("sw_after_addr", 32'(out_addr), 32'd3);
        check_state("sw_done");

        // BEQ
        req(4, 0, 1, 2, 16); tick(); idle();
        chk("beq_word", out_inst, 32'h00208863);
        check_state("beq");
        tick();

        // Illegal requests: no word, sticky err, address unchanged
        req(7, 1, 2, 3, 0); tick(); idle();
        chk("ill_op7_valid", 32'(out_valid), 32'd0);
        chk("ill_op7_err", 32'(err), 32'd1);
        chk("ill_op7_addr", 32'(out_addr), 32'd4);
        req(4, 0, 1, 2, 13'h0003); tick(); idle(); check_state("ill_beq");
        req(5, 1, 1, 0, 13'h0800); tick(); idle();
        chk("ill_lw_valid", 32'(out_valid), 32'd0);
        chk("ill_lw_err", 32'(err), 32'd1);
        check_state("ill_lw");
        restart = 1'b1; tick(); restart = 1'b0;
        chk("ill_restart_err", 32'(err), 32'd0);
        chk("ill_restart_addr", 32'(out_addr), 32'(BASE));

        // Illegal accept concurrent with an output handshake
        req(2, 1, 2, 3, 0); tick();
        req(7, 0, 0, 0, 0); tick(); idle();
        chk("ill_hs_valid", 32'(out_valid), 32'd0);
        chk("ill_hs_addr", 32'(out_addr), 32'd1);
        chk("ill_hs_err", 32'(err), 32'd1);
        check_state("ill_hs");

        // Restart discards a stalled word
        out_ready = 1'b0;
        req(0, 1, 1, 1, 0); tick(); idle();
        restart = 1'b1; tick(); restart = 1'b0; out_ready = 1'b1;
        check_state("restart_stall");

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_imm    = ($urandom_range(0, 1) != 0) ? 13'($urandom) : 13'($urandom_range(0, 64) * 2);
            out_ready = ($urandom_range(0, 3) != 0);
            restart   = ($urandom_range(0, 49) == 0);
            chk_ready("rnd_rdy");
            tick();
            check_state("rnd");
        end
        idle(); restart = 1'b0; out_ready = 1'b1;
        tick();

        // Narrow instance: wraps to 0 (not BASE2), then async reset mid-stall
        req(0, 1, 2, 3, 0);
        in_valid_w = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("wrap_valid", 32'(out_valid_w), 32'd1);
            chk("wrap_addr", 32'(out_addr_w), 32'((BASE2 + k) % 4));
        end
        out_ready_w = 1'b0;
        tick();
        chk("w_stall_rdy", 32'(in_ready_w), 32'd0);
        chk("w_stall_valid", 32'(out_valid_w), 32'd1);
        #1 rst_n_w = 1'b0;
        #1;
        chk("w_async_valid", 32'(out_valid_w), 32'd0);
        chk("w_async_inst", out_inst_w, 32'd0);
        chk("w_async_addr", 32'(out_addr_w), 32'(BASE2));
        chk("w_async_err", 32'(err_w), 32'd0);
        in_valid_w = 1'b0; idle();
        #1 rst_n_w = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
